// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder on a 128-bit bus backed by a 2**IDX_W x 128-bit register array, with a 2-entry in-order response FIFO.
// Optional build macro TLRAM_DENY_OOR_EN: deny requests whose address bits above the array index are nonzero.
module tl_ul_sram_responder #(
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 4,
    parameter int IDX_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [2:0]        a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [15:0]       a_mask,
    input  logic [127:0]      a_data,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [2:0]        d_param,
    output logic [2:0]        d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic              d_denied,
    output logic              d_corrupt,
    output logic [127:0]      d_data
);
    localparam int DEPTH = 1 << IDX_W;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [2:0]       size;
        logic [SRC_W-1:0] source;
        logic             denied;
        logic             corrupt;
        logic [127:0]     data;
    } rsp_t;

    logic [127:0]     mem_q [DEPTH];
    rsp_t             fifo_q [2];
    logic [1:0]       cnt_q, cnt_d;
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;

    logic [IDX_W-1:0] idx;
    logic             oor, bad_op, denied, is_put;
    logic             push, pop, wr_en;
    logic [127:0]     wr_word_d;
    rsp_t             rsp_d, head;
    logic             unused_bits;

    assign unused_bits = ^{a_param, a_address};

    // Request decode and response formation
    always_comb begin
        idx = a_address[4+IDX_W-1:4];
`ifdef TLRAM_DENY_OOR_EN
        oor = |a_address[ADDR_W-1:4+IDX_W];
`else
        oor = 1'b0;
`endif
        case (a_opcode)
            3'd0, 3'd1, 3'd4, 3'd5: bad_op = 1'b0;
            default:                bad_op = 1'b1;
        endcase
        denied = bad_op | (a_size > 3'd4) | oor;
        is_put = (a_opcode == 3'd0) | (a_opcode == 3'd1);

        rsp_d = '0;
        case (a_opcode)
            3'd2, 3'd3, 3'd4: rsp_d.opcode = 3'd1;
            3'd5:             rsp_d.opcode = 3'd2;
            default:          rsp_d.opcode = 3'd0;
        endcase
        rsp_d.size    = a_size;
        rsp_d.source  = a_source;
        rsp_d.denied  = denied;
        rsp_d.corrupt = denied & (rsp_d.opcode == 3'd1);
        rsp_d.data    = ((rsp_d.opcode == 3'd1) && !denied) ? mem_q[idx] : 128'd0;

        for (int b = 0; b < 16; b++) begin
            wr_word_d[8*b +: 8] = a_mask[b] ? a_data[8*b +: 8] : mem_q[idx][8*b +: 8];
        end
    end

    assign a_ready = reset_n & (cnt_q < 2'd2);
    assign push    = a_valid & a_ready;
    assign pop     = d_valid & d_ready;
    assign wr_en   = push & is_put & ~denied;

    always_comb begin
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        wptr_d = push ? ~wptr_q : wptr_q;
        rptr_d = pop  ? ~rptr_q : rptr_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= 2'd0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage carries no reset; a_ready is low in reset so nothing is written.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[idx] <= wr_word_d;
        if (push)  fifo_q[wptr_q] <= rsp_d;
    end

    always_comb begin
        head      = fifo_q[rptr_q];
        d_valid   = (cnt_q != 2'd0);
        d_param   = 3'd0;
        d_opcode  = d_valid ? head.opcode  : 3'd0;
        d_size    = d_valid ? head.size    : 3'd0;
        d_source  = d_valid ? head.source  : '0;
        d_denied  = d_valid ? head.denied  : 1'b0;
        d_corrupt = d_valid ? head.corrupt : 1'b0;
        d_data    = d_valid ? head.data    : 128'd0;
    end
endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed bench for tl_ul_sram_responder: vector table of single transactions plus hand-written backpressure, bypass and reset sequences.
module tb_tl_ul_sram_responder;
    logic         clock = 1'b0;
    logic         reset_n;
    logic         a_valid, a_ready;
    logic [2:0]   a_opcode, a_param, a_size;
    logic [3:0]   a_source;
    logic [31:0]  a_address;
    logic [15:0]  a_mask;
    logic [127:0] a_data;
    logic         d_valid, d_ready;
    logic [2:0]   d_opcode, d_param, d_size;
    logic [3:0]   d_source;
    logic         d_denied, d_corrupt;
    logic [127:0] d_data;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]   op;
        logic [2:0]   size;
        logic [3:0]   src;
        logic [31:0]  addr;
        logic [15:0]  mask;
        logic [127:0] data;
        logic [2:0]   e_op;
        logic         e_den;
        logic         e_cor;
        logic [127:0] e_data;
    } vec_t;

    localparam logic [127:0] D1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D1A = 128'h0123456789ABCDEF0123456789ABCDAA;
    localparam logic [127:0] D2  = 128'hDEADBEEFCAFEF00D1122334455667788;
    localparam logic [127:0] D3  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] D4  = 128'h5523456789ABCDEF0123456789ABCDAA;
    localparam logic [127:0] D5  = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

    vec_t vt [16];

    tl_ul_sram_responder #(.ADDR_W(32), .SRC_W(4), .IDX_W(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_param(d_param), .d_size(d_size), .d_source(d_source), .d_denied(d_denied),
        .d_corrupt(d_corrupt), .d_data(d_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                         input logic [31:0] addr, input logic [15:0] mask, input logic [127:0] data);
        a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
        a_address = addr; a_mask = mask; a_data = data;
    endtask

    task automatic do_txn(input vec_t v, input int i);
        @(negedge clock);
        drive(v.op, v.size, v.src, v.addr, v.mask, v.data);
        d_ready = 1'b1;
        chk($sformatf("v%0d a_ready", i), {127'd0, a_ready}, 128'd1);
        @(posedge clock);
        #1 a_valid = 1'b0;
        @(negedge clock);
        chk($sformatf("v%0d d_valid", i), {127'd0, d_valid}, 128'd1);
        chk($sformatf("v%0d d_opcode", i), {125'd0, d_opcode}, {125'd0, v.e_op});
        chk($sformatf("v%0d d_denied", i), {127'd0, d_denied}, {127'd0, v.e_den});
        chk($sformatf("v%0d d_corrupt", i), {127'd0, d_corrupt}, {127'd0, v.e_cor});
        chk($sformatf("v%0d d_data", i), d_data, v.e_data);
        chk($sformatf("v%0d d_source", i), {124'd0, d_source}, {124'd0, v.src});
        chk($sformatf("v%0d d_size", i), {125'd0, d_size}, {125'd0, v.size});
        chk($sformatf("v%0d d_param", i), {125'd0, d_param}, 128'd0);
    endtask

    initial begin
        vt[0]  = '{3'd0, 3'd4, 4'd3, 32'h20, 16'hFFFF, D1, 3'd0, 1'b0, 1'b0, 128'd0};
        vt[1]  = '{3'd4, 3'd4, 4'd3, 32'h20, 16'h0, 128'd0, 3'd1, 1'b0, 1'b0, D1};
        vt[2]  = '{3'd1, 3'd0, 4'd5, 32'h20, 16'h0001, 128'hAA, 3'd0, 1'b0, 1'b0, 128'd0};
        vt[3]  = '{3'd4, 3'd4, 4'd5, 32'h20, 16'h0, 128'd0, 3'd1, 1'b0, 1'b0, D1A};
        vt[4]  = '{3'd0, 3'd4, 4'd1, 32'h40, 16'hFFFF, D2, 3'd0, 1'b0, 1'b0, 128'd0};
        vt[5]  = '{3'd2, 3'd4, 4'd2, 32'h40, 16'hFFFF, {128{1'b1}}, 3'd1, 1'b1, 1'b1, 128'd0};
        vt[6]  = '{3'd4, 3'd4, 4'd2, 32'h40, 16'h0, 128'd0, 3'd1, 1'b0, 1'b0, D2};
        vt[7]  = '{3'd0, 3'd4, 4'd4, 32'h00, 16'hFFFF, D3, 3'd0, 1'b0, 1'b0, 128'd0};
`ifdef TLRAM_DENY_OOR_EN
        vt[8]  = '{3'd4, 3'd4, 4'd6, 32'h100, 16'h0, 128'd0, 3'd1, 1'b1, 1'b1, 128'd0};
`else
        vt[8]  = '{3'd4, 3'd4, 4'd6, 32'h100, 16'h0, 128'd0, 3'd1, 1'b0, 1'b0, D3};
`endif
        vt[9]  = '{3'd5, 3'd2, 4'd7, 32'h20, 16'h0, 128'd0, 3'd2, 1'b0, 1'b0, 128'd0};
        vt[10] = '{3'd4, 3'd5, 4'hF, 32'h20, 16'h0, 128'd0, 3'd1, 1'b1, 1'b1, 128'd0};
        vt[11] = '{3'd0, 3'd5, 4'd8, 32'h20, 16'hFFFF, 128'd0, 3'd0, 1'b1, 1'b0, 128'd0};
        vt[12] = '{3'd6, 3'd4, 4'd9, 32'h20, 16'hFFFF, 128'd0, 3'd0, 1'b1, 1'b0, 128'd0};
        vt[13] = '{3'd3, 3'd4, 4'hA, 32'h20, 16'hFFFF, 128'd0, 3'd1, 1'b1, 1'b1, 128'd0};
        vt[14] = '{3'd1, 3'd4, 4'hB, 32'h20, 16'h8000, {8'h55, 120'd0}, 3'd0, 1'b0, 1'b0, 128'd0};
        vt[15] = '{3'd4, 3'd4, 4'hC, 32'h20, 16'h0, 128'd0, 3'd1, 1'b0, 1'b0, D4};

        reset_n = 1'b1; a_valid = 1'b0; d_ready = 1'b0; a_param = 3'd0;
        drive(3'd4, 3'd4, 4'd0, 32'h0, 16'h0, 128'd0);
        a_valid = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset d_valid", {127'd0, d_valid}, 128'd0);
        chk("reset a_ready", {127'd0, a_ready}, 128'd0);
        chk("reset d_data", d_data, 128'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) do_txn(vt[i], i);

        // Back-to-back Put then Get of the same entry; enqueue and dequeue together at count 1
        @(negedge clock);
        d_ready = 1'b1;
        drive(3'd0, 3'd4, 4'd1, 32'h60, 16'hFFFF, D5);
        @(negedge clock);
        chk("b2b a_ready", {127'd0, a_ready}, 128'd1);
        chk("b2b put opcode", {125'd0, d_opcode}, 128'd0);
        chk("b2b put source", {124'd0, d_source}, 128'd1);
        drive(3'd4, 3'd4, 4'd2, 32'h60, 16'h0, 128'd0);
        @(negedge clock);
        a_valid = 1'b0;
        chk("b2b get valid", {127'd0, d_valid}, 128'd1);
        chk("b2b get source", {124'd0, d_source}, 128'd2);
        chk("b2b get opcode", {125'd0, d_opcode}, 128'd1);
        chk("b2b get data", d_data, D5);
        @(negedge clock);
        chk("b2b drained", {127'd0, d_valid}, 128'd0);

        // Backpressure: two Gets fill the FIFO, third is refused
        d_ready = 1'b0;
        drive(3'd4, 3'd4, 4'd1, 32'h20, 16'h0, 128'd0);
        @(negedge clock);
        drive(3'd4, 3'd4, 4'd2, 32'h40, 16'h0, 128'd0);
        chk("bp second a_ready", {127'd0, a_ready}, 128'd1);
        @(negedge clock);
        drive(3'd4, 3'd4, 4'd3, 32'h00, 16'h0, 128'd0);
        chk("bp third a_ready", {127'd0, a_ready}, 128'd0);
        chk("bp head source", {124'd0, d_source}, 128'd1);
        @(negedge clock);
        chk("bp hold source", {124'd0, d_source}, 128'd1);
        chk("bp hold data", d_data, D4);
        a_valid = 1'b0;
        d_ready = 1'b1;
        chk("bp full with d_ready", {127'd0, a_ready}, 128'd0);
        @(negedge clock);
        chk("bp drain2 source", {124'd0, d_source}, 128'd2);
        chk("bp drain2 data", d_data, D2);
        @(negedge clock);
        chk("bp empty", {127'd0, d_valid}, 128'd0);

        // Reset with two responses pending and a Put waiting
        d_ready = 1'b0;
        drive(3'd4, 3'd4, 4'd4, 32'h20, 16'h0, 128'd0);
        @(negedge clock);
        drive(3'd4, 3'd4, 4'd5, 32'h40, 16'h0, 128'd0);
        @(negedge clock);
        drive(3'd0, 3'd4, 4'd6, 32'h20, 16'hFFFF, 128'd0);
        chk("rst full d_valid", {127'd0, d_valid}, 128'd1);
        reset_n = 1'b0;
        #1;
        chk("rst async d_valid", {127'd0, d_valid}, 128'd0);
        chk("rst async a_ready", {127'd0, a_ready}, 128'd0);
        chk("rst async d_source", {124'd0, d_source}, 128'd0);
        repeat (2) @(negedge clock);
        a_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("rst release a_ready", {127'd0, a_ready}, 128'd1);
        chk("rst release d_valid", {127'd0, d_valid}, 128'd0);
        do_txn(vt[15], 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
